mon_exp_param: RTL
==================

Name: mon_exp_param

Overview:
Parametrised Montgomery modular exponentiator with a self-contained bit-serial Montgomery product datapath. Computes ans = M^e mod n from Montgomery-domain inputs, using left-to-right square-and-multiply. An optional final multiply-by-1 leaves the result in the normal domain. Sits between the RSA key/message registers and the output formatter; the next generation of the fixed 64-bit exponentiator.

Parameters:
WIDTH, 64, operand/modulus width in bits (>=4)
EXP_WIDTH, 64, exponent width in bits (>=1)
FINAL_CONVERT, 1, 1: ans in normal domain (extra MP(x,1)); 0: ans left in Montgomery domain

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only in IDLE
M_bar  input  WIDTH  message in Montgomery form (M*R mod n, R=2^WIDTH); must be < n
x_bar  input  WIDTH  R mod n (Montgomery one); must be < n
e  input  EXP_WIDTH  exponent
n  input  WIDTH  modulus; must be odd
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when ans is valid
err  output  1  set with done when n is even; cleared on next accepted start
ans  output  WIDTH  result; held stable from done until the next accepted start

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, err=0, ans=0; all internal registers 0.
- Accept: start=1 in IDLE latches M_bar, x_bar, e, n into internal registers; later input changes are ignored. start while busy is ignored (no queueing).
- States: IDLE -> LOAD -> {SQR <-> MUL} -> CONV -> FIN -> IDLE.
- LOAD (1 cycle): n[0]=0 -> FIN with err=1, ans=0. Otherwise x=x_bar, bit index i = position of highest set bit of e (priority encoder). e=0 -> CONV (FINAL_CONVERT=1) or FIN with ans=x_bar.
- SQR: x=MP(x,x). Then MUL if e[i]=1. Else, if i=0 go to CONV/FIN, else i=i-1 and go to SQR.
- MUL: x=MP(M_bar,x). Then, if i=0 go to CONV/FIN, else i=i-1 and go to SQR.
- CONV (FINAL_CONVERT=1 only): x=MP(x,1).
- FIN (1 cycle): ans<=x, done=1, busy=0, go to IDLE.
- MP(A,B) datapath, radix-2, WIDTH+2-bit accumulator P:
  - P=0.
  - For k=0..WIDTH-1 (one cycle each): P=P+A[k]*B; if P odd, P=P+n; P=P>>1.
  - One correction cycle: if P>=n, P=P-n.
  - Exactly WIDTH+1 cycles per MP; result < n; no overflow beyond WIDTH+2 bits.
- Latency: N_mp = (t+1) squarings + popcount(e) multiplies + FINAL_CONVERT, where t = index of the MSB of e (no squarings when e=0).
  - done asserts exactly 2 + N_mp*(WIDTH+1) cycles after the accepting edge.
  - Latency depends on e only; this is not a constant-time design.
- Even n: done after exactly 2 cycles, err=1, ans=0.
- Reset mid-operation: aborts immediately. No done pulse. ans=0 after reset.
- start coincident with the FIN cycle: ignored; start must be presented again in IDLE.
- Out-of-range inputs (M_bar or x_bar >= n): result undefined, no hang; done still occurs at the computed latency.

Test Plan:
1. WIDTH=8, EXP_WIDTH=8, FINAL_CONVERT=1; n=13, x_bar=9, M_bar=5 (M=2), e=5 -> ans=6 (2^5 mod 13), err=0, done exactly 56 cycles after start (6 MPs * 9 + 2).
2. Same operands, e=0 -> ans=1, done after 11 cycles. With FINAL_CONVERT=0 -> ans=9, done after 2 cycles.
3. n=12, e=5 -> done after 2 cycles, err=1, ans=0. Next start with n=13 clears err.
4. Pulse start again while busy in scenario 1, and change all inputs mid-run -> ignored, ans=6 at cycle 56. busy is 1 throughout, done pulses exactly once.
5. Deassert rst_n at cycle 20 of scenario 1 -> busy=0, done=0, ans=0 immediately. Rerun after release -> ans=6 at 56 cycles.
6. WIDTH=64: random odd n, M<n, e random, compared against a software modexp model over 1000 vectors -> all ans match; latency matches the formula.

Source files
------------

// File: rtl/mon_exp_param.sv
// mon_exp_param: parametrised Montgomery modular exponentiator.
//
// Computes ans = M^e mod n by left-to-right square-and-multiply. Operands
// arrive already in the Montgomery domain (R = 2^WIDTH). Every modular
// product runs on one shared bit-serial radix-2 Montgomery multiplier that
// takes WIDTH+1 cycles: WIDTH add/reduce/shift steps and then one
// conditional subtraction. With FINAL_CONVERT=1 a closing MP(x,1) brings
// the result back to the normal domain.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - request, sampled only while idle
//   M_bar  - message in Montgomery form (M*R mod n)
//   x_bar  - Montgomery one (R mod n)
//   e      - exponent
//   n      - modulus, must be odd
//   busy   - high from the cycle after acceptance until done
//   done   - one-cycle pulse when ans is valid
//   err    - raised with done when n was even; cleared on the next accept
//   ans    - result, held from done until it is next rewritten
module mon_exp_param #(
  parameter int WIDTH         = 64,
  parameter int EXP_WIDTH     = 64,
  parameter int FINAL_CONVERT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     M_bar,
  input  logic [WIDTH-1:0]     x_bar,
  input  logic [EXP_WIDTH-1:0] e,
  input  logic [WIDTH-1:0]     n,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH-1:0]     ans
);

  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SQR, S_MUL, S_CONV, S_FIN} state_t;

  state_t state, state_nxt, tail_st;

  logic [WIDTH-1:0]     m_r, xb_r, n_r, x_r;
  logic [EXP_WIDTH-1:0] e_r;
  logic [IW-1:0]        idx, msb_idx;
  logic [CW-1:0]        cnt;
  logic [WIDTH+1:0]     p_r;
  logic                 mp_last;

  logic [WIDTH-1:0]     op_a, op_b;
  logic                 a_bit;
  logic [WIDTH+2:0]     sum_add, sum_red;
  logic [WIDTH+1:0]     p_step;
  logic [WIDTH-1:0]     p_corr;

  assign mp_last = (cnt == CW'(WIDTH));
  assign tail_st = (FINAL_CONVERT != 0) ? S_CONV : S_FIN;

  // Priority encoder: highest set bit of the latched exponent.
  always_comb begin
    msb_idx = '0;
    for (int j = 0; j < EXP_WIDTH; j++) begin
      if (e_r[j]) msb_idx = IW'(j);
    end
  end

  // One Montgomery step: P = (P + A[k]*B [+ n]) / 2. With A,B < n and
  // P < 2n the sum stays below 4n, so WIDTH+2 bits hold it; the extra top
  // bit only keeps out-of-range operands from wrapping mid-step.
  always_comb begin
    op_a    = (state == S_MUL) ? m_r : x_r;
    op_b    = (state == S_CONV) ? WIDTH'(1) : x_r;
    a_bit   = |(op_a & (WIDTH'(1) << cnt));
    sum_add = {1'b0, p_r} + (a_bit ? {3'b000, op_b} : '0);
    sum_red = sum_add[0] ? (sum_add + {3'b000, n_r}) : sum_add;
    p_step  = (WIDTH + 2)'(sum_red >> 1);
    p_corr  = (p_r >= {2'b00, n_r}) ? WIDTH'(p_r - {2'b00, n_r}) : WIDTH'(p_r);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        if (!n_r[0])         state_nxt = S_FIN;
        else if (e_r == '0)  state_nxt = tail_st;
        else                 state_nxt = S_SQR;
      end
      S_SQR: begin
        if (mp_last) begin
          if (e_r[idx])        state_nxt = S_MUL;
          else if (idx == '0)  state_nxt = tail_st;
          else                 state_nxt = S_SQR;
        end
      end
      S_MUL: begin
        if (mp_last) state_nxt = (idx == '0) ? tail_st : S_SQR;
      end
      S_CONV: if (mp_last) state_nxt = S_FIN;
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_r  <= '0;
      xb_r <= '0;
      n_r  <= '0;
      e_r  <= '0;
      x_r  <= '0;
      idx  <= '0;
      cnt  <= '0;
      p_r  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      ans  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            m_r  <= M_bar;
            xb_r <= x_bar;
            e_r  <= e;
            n_r  <= n;
            busy <= 1'b1;
            err  <= 1'b0;
          end
        end
        S_LOAD: begin
          // An even modulus forces a zero result.
          x_r <= n_r[0] ? xb_r : '0;
          idx <= msb_idx;
          cnt <= '0;
          p_r <= '0;
        end
        S_SQR, S_MUL, S_CONV: begin
          if (mp_last) begin
            x_r <= p_corr;
            p_r <= '0;
            cnt <= '0;
            // Move to the next exponent bit only when starting a new squaring.
            if (state_nxt == S_SQR) idx <= idx - IW'(1);
          end else begin
            p_r <= p_step;
            cnt <= cnt + CW'(1);
          end
        end
        S_FIN: begin
          ans  <= x_r;
          done <= 1'b1;
          busy <= 1'b0;
          err  <= ~n_r[0];
        end
        default: ;
      endcase
    end
  end

endmodule
